// File: rtl/dataflow_gen2.sv
// Spiking-conv dataflow controller: scans an H x W frame over T+1 timesteps, strobes EN/FT/BUSY per kernel window,
// and runs the memristor power-down FSM. Optional stride support is compiled in with DATAFLOW_STRIDE_EN.
module dataflow_gen2 #(
  parameter int H_WIDTH   = 5,
  parameter int W_WIDTH   = 5,
  parameter int T_WIDTH   = 5,
  parameter int TPD_WIDTH = 4,
  parameter int S_WIDTH   = 2,
  parameter int KH        = 4,
  parameter int KW        = 4,
  parameter int EN_LEN    = 1,
  parameter int BUSY_LEN  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  input  logic                 IN_VALID_INTERNAL,
  input  logic [H_WIDTH-1:0]   H,
  input  logic [W_WIDTH-1:0]   W,
  input  logic [T_WIDTH-1:0]   T,
  input  logic [S_WIDTH-1:0]   STRIDE,
  input  logic [TPD_WIDTH-1:0] TPD,
  input  logic                 BP,
  output logic                 EN,
  output logic                 FT,
  output logic                 BUSY,
  output logic [H_WIDTH-1:0]   OH,
  output logic [W_WIDTH-1:0]   OW,
  output logic                 LAST,
  output logic                 PD
);

  localparam int PC_W = (BUSY_LEN < 2) ? 1 : $clog2(BUSY_LEN + 1);
  localparam logic [W_WIDTH-1:0] KW_M1      = W_WIDTH'(KW - 1);
  localparam logic [H_WIDTH-1:0] KH_M1      = H_WIDTH'(KH - 1);
  localparam logic [PC_W-1:0]    EN_LEN_C   = PC_W'(EN_LEN);
  localparam logic [PC_W-1:0]    BUSY_LEN_C = PC_W'(BUSY_LEN);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_DRAIN} state_t;

  logic [T_WIDTH-1:0]   t_q, t_d;
  logic [W_WIDTH-1:0]   w_q, w_d, ow_q, ow_d;
  logic [H_WIDTH-1:0]   h_q, h_d, oh_q, oh_d;
  logic                 beat, t_last, w_last, h_last;
  logic                 w_adv, h_adv, w_wrap, h_wrap, frame_end;
  logic                 pw_zero, ph_zero, cv, rv, hit;
  logic                 origin, wake;

  logic                 en_q, en_d, ft_q, ft_d, busy_q, busy_d, last_q, last_d;
  logic [H_WIDTH-1:0]   oh_out_q, oh_out_d;
  logic [W_WIDTH-1:0]   ow_out_q, ow_out_d;
  logic [PC_W-1:0]      pc_q, pc_d, pc_inc;

  state_t               state_q, state_d;
  logic [TPD_WIDTH-1:0] pd_cnt_q, pd_cnt_d;

  assign beat      = IN_VALID_INTERNAL;
  assign t_last    = (t_q == T);
  assign w_last    = (w_q == W);
  assign h_last    = (h_q == H);
  assign w_adv     = beat && t_last;
  assign w_wrap    = w_adv && w_last;
  assign h_adv     = w_wrap;
  assign h_wrap    = h_adv && h_last;
  assign frame_end = h_wrap;

  assign cv  = (w_q >= KW_M1) && pw_zero;
  assign rv  = (h_q >= KH_M1) && ph_zero;
  assign hit = beat && cv && rv;

  assign origin = (t_q == '0) && (w_q == '0) && (h_q == '0);
  assign wake   = IN_VALID && origin;

  always_comb begin
    t_d  = t_q;
    w_d  = w_q;
    h_d  = h_q;
    ow_d = ow_q;
    oh_d = oh_q;
    if (beat) begin
      t_d = t_last ? '0 : t_q + 1'b1;
    end
    if (w_adv) begin
      w_d = w_last ? '0 : w_q + 1'b1;
      if (w_last) begin
        ow_d = '0;
      end else if (cv) begin
        ow_d = ow_q + 1'b1;
      end
    end
    if (h_adv) begin
      h_d = h_last ? '0 : h_q + 1'b1;
      if (h_last) begin
        oh_d = '0;
      end else if (rv) begin
        oh_d = oh_q + 1'b1;
      end
    end
  end

`ifdef DATAFLOW_STRIDE_EN
  logic [S_WIDTH-1:0] pw_q, pw_d, ph_q, ph_d;

  // Phases only start counting once the kernel fully fits; phase 0 marks a valid window.
  always_comb begin
    pw_d = pw_q;
    ph_d = ph_q;
    if (w_wrap) begin
      pw_d = '0;
    end else if (w_adv && (w_q >= KW_M1)) begin
      pw_d = (pw_q == STRIDE) ? '0 : pw_q + 1'b1;
    end
    if (h_wrap) begin
      ph_d = '0;
    end else if (h_adv && (h_q >= KH_M1)) begin
      ph_d = (ph_q == STRIDE) ? '0 : ph_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pw_q <= '0;
      ph_q <= '0;
    end else begin
      pw_q <= pw_d;
      ph_q <= ph_d;
    end
  end

  assign pw_zero = (pw_q == '0);
  assign ph_zero = (ph_q == '0);
`else
  logic unused_stride;
  assign unused_stride = ^STRIDE;
  assign pw_zero       = 1'b1;
  assign ph_zero       = 1'b1;
`endif

  // A new hit restarts both pulse windows; otherwise they age out via the shared counter.
  always_comb begin
    en_d     = en_q;
    ft_d     = ft_q;
    busy_d   = busy_q;
    oh_out_d = oh_out_q;
    ow_out_d = ow_out_q;
    pc_d     = pc_q;
    pc_inc   = pc_q + 1'b1;
    last_d   = frame_end;
    if (hit) begin
      en_d     = 1'b1;
      busy_d   = 1'b1;
      ft_d     = (t_q == '0);
      oh_out_d = oh_q;
      ow_out_d = ow_q;
      pc_d     = '0;
    end else if (busy_q) begin
      pc_d   = pc_inc;
      en_d   = en_q && (pc_inc < EN_LEN_C);
      ft_d   = ft_q && en_d;
      busy_d = (pc_inc < BUSY_LEN_C);
    end
  end

  always_comb begin
    state_d  = state_q;
    pd_cnt_d = '0;
    case (state_q)
      S_OFF: begin
        if (wake) state_d = S_RUN;
      end
      S_RUN: begin
        if (frame_end) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        pd_cnt_d = (pd_cnt_q == TPD) ? pd_cnt_q : pd_cnt_q + 1'b1;
        if (wake) begin
          state_d = S_RUN;
        end else if (pd_cnt_q == TPD) begin
          state_d = S_OFF;
        end
      end
      default: state_d = S_OFF;
    endcase
    if (BP) begin
      state_d  = S_OFF;
      pd_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      t_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      ow_q     <= '0;
      oh_q     <= '0;
      en_q     <= 1'b0;
      ft_q     <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= 1'b0;
      oh_out_q <= '0;
      ow_out_q <= '0;
      pc_q     <= '0;
      state_q  <= S_OFF;
      pd_cnt_q <= '0;
    end else begin
      t_q      <= t_d;
      w_q      <= w_d;
      h_q      <= h_d;
      ow_q     <= ow_d;
      oh_q     <= oh_d;
      en_q     <= en_d;
      ft_q     <= ft_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
      oh_out_q <= oh_out_d;
      ow_out_q <= ow_out_d;
      pc_q     <= pc_d;
      state_q  <= state_d;
      pd_cnt_q <= pd_cnt_d;
    end
  end

  assign EN   = en_q;
  assign FT   = ft_q;
  assign BUSY = busy_q;
  assign OH   = oh_out_q;
  assign OW   = ow_out_q;
  assign LAST = last_q;
  assign PD   = (state_q == S_OFF);

endmodule

// File: tb/tb_dataflow_gen2.sv
// Directed bench for dataflow_gen2: table of frame scans plus power-down, bypass and reset sequences.
module tb_dataflow_gen2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       IN_VALID = 1'b0;
  logic       IN_VALID_INTERNAL = 1'b0;
  logic [4:0] H = '0, W = '0, T = '0;
  logic [1:0] STRIDE = '0;
  logic [3:0] TPD = 4'd5;
  logic       BP = 1'b0;
  logic       EN, FT, BUSY, LAST, PD;
  logic [4:0] OH, OW;

  int checks = 0;
  int failures = 0;

  dataflow_gen2 dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_VALID_INTERNAL(IN_VALID_INTERNAL),
    .H(H), .W(W), .T(T), .STRIDE(STRIDE), .TPD(TPD), .BP(BP),
    .EN(EN), .FT(FT), .BUSY(BUSY), .OH(OH), .OW(OW), .LAST(LAST), .PD(PD)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int h, w, t, s, beats, ncol;
    int en, ft, busy, last_beat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    IN_VALID = 1'b0;
    IN_VALID_INTERNAL = 1'b0;
    BP = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Streams beats then idles for tail cycles, sampling each cycle at the falling edge.
  task automatic run_frame(input int beats, input int ncol, input bit wake, input int bp_beat,
                           input int tail, output int en_c, output int ft_c, output int busy_c,
                           output int last_c, output int last_b, output int pd_low);
    int win;
    win = 0;
    en_c = 0; ft_c = 0; busy_c = 0; last_c = 0; last_b = 0; pd_low = 0;
    for (int k = 1; k <= beats + tail; k++) begin
      IN_VALID_INTERNAL = (k <= beats);
      IN_VALID = wake && (k == 1);
      BP = (k == bp_beat);
      @(negedge CLK);
      if (EN) en_c++;
      if (BUSY) busy_c++;
      if (!PD) pd_low++;
      if (LAST) begin
        last_c++;
        last_b = k;
      end
      if (EN && FT) begin
        ft_c++;
        chk("oh", int'(OH), win / ncol);
        chk("ow", int'(OW), win % ncol);
        win++;
      end
    end
    IN_VALID_INTERNAL = 1'b0;
    IN_VALID = 1'b0;
    BP = 1'b0;
  endtask

  initial begin
    vec_t vecs[4];
    int en_c, ft_c, busy_c, last_c, last_b, pd_low, first_hi, pd_hi;

    vecs[0] = '{h: 5, w: 5, t: 0, s: 0, beats: 36, ncol: 3, en: 9, ft: 9, busy: 12, last_beat: 36};
`ifdef DATAFLOW_STRIDE_EN
    vecs[1] = '{h: 7, w: 7, t: 0, s: 1, beats: 64, ncol: 3, en: 9, ft: 9, busy: 18, last_beat: 64};
`else
    vecs[1] = '{h: 7, w: 7, t: 0, s: 1, beats: 64, ncol: 5, en: 25, ft: 25, busy: 30, last_beat: 64};
`endif
    vecs[2] = '{h: 3, w: 3, t: 3, s: 0, beats: 64, ncol: 1, en: 4, ft: 1, busy: 5, last_beat: 64};
    vecs[3] = '{h: 4, w: 3, t: 1, s: 0, beats: 40, ncol: 1, en: 4, ft: 2, busy: 6, last_beat: 40};

    // Reset state
    @(negedge CLK);
    chk("rst_en", int'(EN), 0);
    chk("rst_ft", int'(FT), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_last", int'(LAST), 0);
    chk("rst_oh", int'(OH), 0);
    chk("rst_ow", int'(OW), 0);
    chk("rst_pd", int'(PD), 1);
    RST = 1'b0;

    foreach (vecs[i]) begin
      H = 5'(vecs[i].h);
      W = 5'(vecs[i].w);
      T = 5'(vecs[i].t);
      STRIDE = 2'(vecs[i].s);
      do_reset();
      run_frame(vecs[i].beats, vecs[i].ncol, 1'b0, 0, 4, en_c, ft_c, busy_c, last_c, last_b, pd_low);
      chk($sformatf("v%0d_en", i), en_c, vecs[i].en);
      chk($sformatf("v%0d_ft", i), ft_c, vecs[i].ft);
      chk($sformatf("v%0d_busy", i), busy_c, vecs[i].busy);
      chk($sformatf("v%0d_last_cnt", i), last_c, 1);
      chk($sformatf("v%0d_last_beat", i), last_b, vecs[i].last_beat);
    end

    // Power-down delay: TPD=5, 2x2 frame with no kernel hits
    H = 5'd1; W = 5'd1; T = 5'd0; STRIDE = 2'd0; TPD = 4'd5;
    do_reset();
    run_frame(4, 1, 1'b1, 0, 0, en_c, ft_c, busy_c, last_c, last_b, pd_low);
    chk("pd_run_low", pd_low, 4);
    first_hi = 0;
    for (int d = 1; d <= 10; d++) begin
      @(negedge CLK);
      if (PD && first_hi == 0) first_hi = d;
    end
    chk("pd_drain_delay", first_hi, 6);
    run_frame(4, 1, 1'b1, 0, 0, en_c, ft_c, busy_c, last_c, last_b, pd_low);
    chk("pd_run2_low", pd_low, 4);
    pd_hi = 0;
    for (int d = 1; d <= 10; d++) begin
      IN_VALID = (d == 3);
      @(negedge CLK);
      if (PD) pd_hi++;
    end
    IN_VALID = 1'b0;
    chk("pd_rewake_hi", pd_hi, 0);

    // Bypass mid-frame
    H = 5'd5; W = 5'd5; T = 5'd0;
    do_reset();
    run_frame(36, 3, 1'b1, 10, 3, en_c, ft_c, busy_c, last_c, last_b, pd_low);
    chk("bp_pd_low", pd_low, 9);
    chk("bp_en", en_c, 9);
    chk("bp_last_beat", last_b, 36);
    IN_VALID = 1'b1; BP = 1'b1;
    @(negedge CLK);
    chk("bp_priority_pd", int'(PD), 1);
    BP = 1'b0;
    @(negedge CLK);
    chk("bp_wake_pd", int'(PD), 0);
    IN_VALID = 1'b0;

    // Reset during an EN pulse
    H = 5'd3; W = 5'd3; T = 5'd3;
    do_reset();
    run_frame(62, 1, 1'b1, 0, 0, en_c, ft_c, busy_c, last_c, last_b, pd_low);
    chk("mid_en_pre", int'(EN), 1);
    RST = 1'b1;
    #1;
    chk("mid_rst_en", int'(EN), 0);
    chk("mid_rst_ft", int'(FT), 0);
    chk("mid_rst_busy", int'(BUSY), 0);
    chk("mid_rst_last", int'(LAST), 0);
    chk("mid_rst_pd", int'(PD), 1);
    @(negedge CLK);
    RST = 1'b0;
    run_frame(64, 1, 1'b0, 0, 4, en_c, ft_c, busy_c, last_c, last_b, pd_low);
    chk("restart_en", en_c, 4);
    chk("restart_ft", ft_c, 1);
    chk("restart_last_beat", last_b, 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dataflow_gen2.md
Name: dataflow_gen2

Overview:
Second-generation spiking-conv dataflow controller. Walks an H x W input frame over T+1 timesteps and raises window-enable (EN), first-timestep (FT) and busy (BUSY) strobes for every valid KH x KW kernel position under a programmable stride. Emits output-map coordinates and an end-of-frame pulse, and runs a 3-state power-down FSM for the memristor array. Sits between the input FIFO and the crossbar/neuron array.

Parameters:
H_WIDTH, 5, width of row counter and H input
W_WIDTH, 5, width of column counter and W input
T_WIDTH, 5, width of timestep counter
TPD_WIDTH, 4, width of power-down delay counter
S_WIDTH, 2, width of STRIDE input
KH, 4, kernel rows (>=1)
KW, 4, kernel columns (>=1)
EN_LEN, 1, EN/FT pulse length in cycles (>=1)
BUSY_LEN, 2, BUSY pulse length in cycles (>=EN_LEN)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
IN_VALID  in  1  external input beat; used only for frame-start PD wake
IN_VALID_INTERNAL  in  1  internal input beat; advances counters
H  in  H_WIDTH  rows-1
W  in  W_WIDTH  columns-1
T  in  T_WIDTH  timesteps-1
STRIDE  in  S_WIDTH  stride-1 (0 = stride 1), both axes
TPD  in  TPD_WIDTH  power-down delay
BP  in  1  bypass: force power-down
EN  out  1  window enable
FT  out  1  first-timestep flag, qualifies EN
BUSY  out  1  array busy window
OH  out  H_WIDTH  output-map row of current window
OW  out  W_WIDTH  output-map column of current window
LAST  out  1  one-cycle pulse on final beat of frame
PD  out  1  array power-down (1 = powered down)

Behaviour:
- Reset: all counters 0; EN=FT=BUSY=LAST=0; OH=OW=0; FSM=OFF; PD=1.
- Beat = IN_VALID_INTERNAL high. t: 0..T, wraps to 0 on beat at t==T. w advances on beat with t==T, wraps after W. h advances on beat with t==T && w==W, wraps after H. frame_end = beat && t==T && w==W && h==H.
- Stride phases pw/ph: pw cleared on w wrap; on w advance with w>=KW-1, pw <= (pw==STRIDE)?0:pw+1. ph identical on h with KH-1 and h wrap.
- Column valid cv = w>=KW-1 && pw==0; row valid rv = h>=KH-1 && ph==0. Window hit e = beat && cv && rv (combinational).
- Window indices ow/oh: ow cleared on w wrap, incremented on w advance when cv; oh cleared on h wrap, incremented on h advance when rv.
- Latency 1: on edge where e=1: EN<=1, BUSY<=1, FT<=(t==0), OH<=oh, OW<=ow, pulse counter cleared. EN/FT held EN_LEN cycles, BUSY held BUSY_LEN cycles, then fall. New e while pulsing restarts both windows (retrigger, no gap). OH/OW hold between hits.
- LAST <= frame_end, one cycle.
- PD FSM: OFF (PD=1), RUN (PD=0), DRAIN (PD=0). OFF/DRAIN -> RUN on IN_VALID && t==0 && w==0 && h==0. RUN -> DRAIN on frame_end. DRAIN: pd_cnt increments from 0 per cycle, saturates at TPD; -> OFF on edge where pd_cnt==TPD; PD rises TPD+1 cycles after entering DRAIN. BP has top priority: any state -> OFF, PD<=1, counters t/w/h unaffected.
- Simultaneous wake and frame_end in RUN: frame_end wins (-> DRAIN).
- Unsigned arithmetic; all counters wrap only at programmed limits; H/W/T/STRIDE changes mid-frame undefined except via RST.
- RST mid-frame: immediate return to reset state, outputs as above.

Optional Feature:
DATAFLOW_STRIDE_EN. Defined: STRIDE behaves as above. Undefined: stride fixed 1; pw/ph phase logic removed (treated as 0), STRIDE port present but ignored.

Test Plan:
- H=W=5, T=0, STRIDE=0, KH=KW=4: stream 36 beats -> 9 EN pulses, (OH,OW) (0,0)..(2,2) row-major, LAST once on beat 36.
- H=W=7, T=0, STRIDE=1: 64 beats -> EN at w,h in {3,5,7}, 9 pulses, OW sequence 0,1,2 per valid row.
- T=3, H=W=3: each hit yields 4 consecutive EN beats; FT high only on first; BUSY stays high continuously (retrigger).
- TPD=5: IN_VALID at origin -> PD=0 next cycle; after frame_end PD returns 1 exactly 6 cycles later; new origin IN_VALID at DRAIN cycle 3 -> PD stays 0.
- BP asserted mid-frame -> PD=1 next cycle, EN hits still generated, PD stays 1 until next origin IN_VALID with BP low.
- RST asserted during an EN pulse -> EN/FT/BUSY/LAST=0, PD=1 immediately; counters restart from 0.
